// File: rtl/game_status.sv
// Player status tracker: life counter, post-hit invulnerability blink
// window and game-over latch. It produces one LED row image per state.
module game_status #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      LIVES        = 3,
  parameter int unsigned      FLASH_TICKS  = 8,
  parameter logic [WIDTH-1:0] OVER_PATTERN = WIDTH'(16'b1111011010010111)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hit,
  input  logic                           tick,
  input  logic                           restart,
  output logic [WIDTH-1:0]               pixels,
  output logic [$clog2(LIVES+1)-1:0]     lives_left,
  output logic                           game_over,
  output logic                           invuln
);

  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned CW = 8;

  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [CW-1:0] FLASH_INIT = CW'(FLASH_TICKS);

  // Elaboration-time guard on the parameter ranges
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("game_status: WIDTH out of range 2..64");
  end
  if (LIVES < 1 || LIVES > WIDTH) begin : g_bad_lives
    $error("game_status: LIVES out of range 1..WIDTH");
  end
  if (FLASH_TICKS < 1 || FLASH_TICKS > 255) begin : g_bad_flash
    $error("game_status: FLASH_TICKS out of range 1..255");
  end

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_FLASH = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lives;
  logic [LW-1:0]   w_lives_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_phase;
  logic            w_phase_nxt;
  logic [WIDTH-1:0] w_therm;

  // State, life count, flash counter and blink phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_PLAY;
      r_lives <= LIVES_INIT;
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lives <= w_lives_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state logic; restart overrides everything, including a same-cycle hit
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;

    if (restart) begin
      w_state_nxt = S_PLAY;
      w_lives_nxt = LIVES_INIT;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (hit) begin
            if (r_lives > LW'(1)) begin
              w_lives_nxt = r_lives - LW'(1);
              w_state_nxt = S_FLASH;
              w_cnt_nxt   = FLASH_INIT;
              w_phase_nxt = 1'b0;
            end else begin
              // Last life gone: straight to game over, no blink window
              w_lives_nxt = '0;
              w_state_nxt = S_OVER;
            end
          end
        end
        S_FLASH: begin
          // Hits are ignored while invulnerable
          if (tick) begin
            w_cnt_nxt   = r_cnt - CW'(1);
            w_phase_nxt = ~r_phase;
            if (r_cnt <= CW'(1)) begin
              w_state_nxt = S_PLAY;
            end
          end
        end
        S_OVER: begin
          w_state_nxt = S_OVER;
        end
        default: begin
          w_state_nxt = S_PLAY;
          w_lives_nxt = LIVES_INIT;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b0;
        end
      endcase
    end
  end

  // Thermometer image of the remaining lives
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_therm[i] = (32'(i) < 32'(r_lives));
    end
  end

  // Row image and status flags decoded from the registered state
  always_comb begin
    pixels    = w_therm;
    game_over = 1'b0;
    invuln    = 1'b0;
    case (r_state)
      S_PLAY: begin
        pixels = w_therm;
      end
      S_FLASH: begin
        invuln = 1'b1;
        pixels = r_phase ? w_therm : '0;
      end
      S_OVER: begin
        game_over = 1'b1;
        pixels    = OVER_PATTERN;
      end
      default: begin
        pixels = w_therm;
      end
    endcase
  end

  assign lives_left = r_lives;

endmodule
